// File: rtl/dat_mem_stk.sv
// Shared DEPTH x W data memory with random-access load/store and a downward-growing hardware stack.
// Latency: 0-cycle combinational read, writes land at the clock edge; backpressure: none, full/empty flags plus sticky err.
module dat_mem_stk #(
    parameter int W  = 8,
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [W-1:0]  dat_in,
    input  logic [AW-1:0] addr,
    input  logic          wr_en,
    input  logic          push,
    input  logic          pop,
    input  logic          err_clr,
    output logic [W-1:0]  dat_out,
    output logic [AW:0]   level,
    output logic          full,
    output logic          empty,
    output logic          err
);

    localparam int          DEPTH     = 1 << AW;
    localparam logic [AW:0] DEPTH_LVL = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE_LVL   = (AW+1)'(1);

    logic [W-1:0]  mem [0:DEPTH-1];
    logic [AW-1:0] top;
    logic [AW-1:0] nxt;
    logic [AW:0]   level_nxt;
    logic          err_set;
    logic          mem_we;
    logic [AW-1:0] mem_wa;
    logic [W-1:0]  mem_wd;

    assign full  = (level == DEPTH_LVL);
    assign empty = (level == '0);

    // DEPTH-n and DEPTH-1-n reduced modulo DEPTH
    assign top = -level[AW-1:0];
    assign nxt = ~level[AW-1:0];

    assign dat_out = (pop && !empty) ? mem[top] : mem[addr];

    always_comb begin
        level_nxt = level;
        err_set   = 1'b0;
        mem_we    = 1'b0;
        mem_wa    = addr;
        mem_wd    = dat_in;
        if (push && pop) begin
            mem_we  = 1'b1;
            err_set = wr_en;
            if (!empty) begin
                mem_wa = top;
            end else begin
                mem_wa    = nxt;
                level_nxt = ONE_LVL;
                err_set   = 1'b1;
            end
        end else if (push) begin
            // a store colliding with a push is dropped and flagged
            err_set = wr_en;
            if (!full) begin
                mem_we    = 1'b1;
                mem_wa    = nxt;
                level_nxt = level + ONE_LVL;
            end else begin
                err_set = 1'b1;
            end
        end else if (pop) begin
            mem_we = wr_en;
            if (!empty) begin
                level_nxt = level - ONE_LVL;
            end else begin
                err_set = 1'b1;
            end
        end else begin
            mem_we = wr_en;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level <= '0;
            err   <= 1'b0;
        end else begin
            level <= level_nxt;
            err   <= err_set | (err & ~err_clr);
        end
    end

    // array has no reset so its contents survive rst_n
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_wa] <= mem_wd;
        end
    end

endmodule
